// File: rtl/dmem_responder.sv
// dmem_responder: responding end of the core data-memory port.
// Serves one byte-enabled load/store at a time after LATENCY wait states.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  output logic        o_gnt,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        acc;
  logic        enter;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [3:0]  cur_be;
  logic [31:0] cur_wdata;
  logic        align_ok;
  logic        range_ok;
  logic        legal;
  logic [31:0] mask;
  logic [IW-1:0] idx;

  assign o_gnt = i_req & (state == IDLE);
  assign acc   = o_gnt;

  // With zero latency the access completes on the grant edge, before
  // the latches are loaded, so the live bus is used in IDLE.
  assign cur_we    = (state == IDLE) ? i_we    : we_q;
  assign cur_addr  = (state == IDLE) ? i_addr  : addr_q;
  assign cur_be    = (state == IDLE) ? i_be    : be_q;
  assign cur_wdata = (state == IDLE) ? i_wdata : wdata_q;

  assign enter = (acc && (LATENCY == 0)) ||
                 ((state == WAIT) && (cnt == 4'd1));

  always_comb begin
    align_ok = 1'b0;
    case (cur_be)
      4'b0001: align_ok = (cur_addr[1:0] == 2'd0);
      4'b0010: align_ok = (cur_addr[1:0] == 2'd1);
      4'b0100: align_ok = (cur_addr[1:0] == 2'd2);
      4'b1000: align_ok = (cur_addr[1:0] == 2'd3);
      4'b0011: align_ok = (cur_addr[1:0] == 2'd0);
      4'b1100: align_ok = (cur_addr[1:0] == 2'd2);
      4'b1111: align_ok = (cur_addr[1:0] == 2'd0);
      default: align_ok = 1'b0;
    endcase
  end

  assign range_ok = {2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS);
  assign legal    = align_ok & range_ok;
  assign idx      = cur_addr[IW+1:2];
  assign mask     = {{8{cur_be[3]}}, {8{cur_be[2]}},
                     {8{cur_be[1]}}, {8{cur_be[0]}}};

  // Storage is deliberately not reset; writes are held off during reset.
  always_ff @(posedge i_clk) begin
    if (i_rstn && enter && cur_we && legal)
      mem[idx] <= (mem[idx] & ~mask) | (cur_wdata & mask);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      o_rvalid <= 1'b0;
      o_rdata  <= 32'd0;
      o_err    <= 1'b0;
    end else begin
      o_rvalid <= enter;
      if (acc) begin
        we_q    <= i_we;
        addr_q  <= i_addr;
        be_q    <= i_be;
        wdata_q <= i_wdata;
      end
      if (enter) begin
        o_err   <= ~legal;
        o_rdata <= (legal && !cur_we) ? (mem[idx] & mask) : 32'd0;
      end
      case (state)
        IDLE: begin
          if (acc) begin
            cnt   <= 4'(LATENCY);
            state <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed traffic against a word-array
// reference model, responses checked by a decoupled scoreboard monitor.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
  localparam int NW    = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        gnt0, rvalid0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_we(we),
    .i_addr(addr), .i_be(be), .i_wdata(wdata),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata), .o_err(err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u0 (
    .i_clk(clk), .i_rstn(rstn), .i_req(req0), .i_we(we0),
    .i_addr(addr0), .i_be(be0), .i_wdata(wdata0),
    .o_gnt(gnt0), .o_rvalid(rvalid0), .o_rdata(rdata0), .o_err(err0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [NW];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          last_gnt = -100;
  int          prev_g = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit legal_m(input logic [31:0] a,
                                 input logic [3:0] b);
    int n;
    int lo;
    logic [3:0] run;
    n = $countones(b);
    if (n == 0 || n == 3) return 1'b0;
    lo = 0;
    while (!b[lo]) lo++;
    run = 4'(((1 << n) - 1) << lo);
    if (run != b) return 1'b0;
    if (int'(a[1:0]) != lo) return 1'b0;
    if ((lo % n) != 0) return 1'b0;
    return {2'b00, a[31:2]} < 32'(DEPTH);
  endfunction

  function automatic logic [31:0] lmask(input logic [3:0] b);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{b[k]}};
    return m;
  endfunction

  task automatic access(input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input bit track, input bit b2b);
    int n;
    int g;
    int wi;
    bit lg;
    logic [31:0] m;
    exp_t e;
    n = 0;
    we = w; addr = a; be = b; wdata = d; req = 1'b1;
    @(negedge clk);
    while (!gnt && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!gnt) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    g = cyc;
    if (b2b) chk("b2b_gap", 32'(g - prev_g), 32'(LAT + 2));
    prev_g = g;
    @(posedge clk);
    #1;
    req = 1'b0;
    if (track) begin
      lg = legal_m(a, b);
      wi = int'(a[31:2]);
      m  = lmask(b);
      if (wi >= NW) lg = 1'b0;
      e.rdata = 32'd0;
      if (w) begin
        if (lg) ref_mem[wi] = (ref_mem[wi] & ~m) | (d & m);
      end else if (lg) begin
        e.rdata = ref_mem[wi] & m;
      end
      e.err = !lg;
      e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (gnt) begin
          chk("gnt_spacing", 32'(cyc - last_gnt >= LAT + 2), 32'd1);
          last_gnt = cyc;
        end
        if (rvalid) begin
          if (sb.size() == 0) begin
            chk("spurious_rvalid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("err", 32'(err), 32'(e.err));
            chk("latency", 32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  b;
    int          sz;
    int          n;
    bit          b2b;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;

    req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt_follows_req", 32'(gnt), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    req = 1'b0;
    #1;
    chk("rst_gnt_low", 32'(gnt), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    last_gnt = -100;

    for (int i = 0; i < NW; i++)
      access(1'b1, 32'(i * 4), 4'hF, $urandom, 1'b1, i > 0);

    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 1'b1);
    access(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b1, 1'b1);
    access(1'b1, 32'h21, 4'b0010, 32'h0000AA00, 1'b1, 1'b1);
    access(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b1);
    access(1'b0, 32'h23, 4'b1000, 32'h0, 1'b1, 1'b1);
    access(1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1);
    access(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, 1'b1);
    access(1'b0, 32'h20, 4'b0101, 32'h0, 1'b1, 1'b1);
    access(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 1'b1);
    chk("model_merge", ref_mem[8], 32'h1122AA44);

    repeat (LAT + 3) @(posedge clk);
    #1;
    access(1'b1, 32'h30, 4'hF, 32'h55, 1'b0, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    last_gnt = -100;
    repeat (LAT + 3) @(posedge clk);
    #1;
    access(1'b0, 32'h30, 4'hF, 32'h0, 1'b1, 1'b0);

    b2b = 1'b1;
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        b2b = 1'b0;
      end
      if ($urandom_range(0, 9) == 0)
        a = 32'h1000 + 32'($urandom_range(0, 255));
      else
        a = 32'($urandom_range(0, NW * 4 - 1));
      if ($urandom_range(0, 2) == 0) begin
        b = 4'($urandom_range(0, 15));
      end else begin
        sz = $urandom_range(0, 2);
        if (sz == 0) begin
          b = 4'(1 << a[1:0]);
        end else if (sz == 1) begin
          a[0] = 1'b0;
          b = a[1] ? 4'b1100 : 4'b0011;
        end else begin
          a[1:0] = 2'b00;
          b = 4'hF;
        end
      end
      access(1'($urandom_range(0, 1)), a, b, $urandom, 1'b1, b2b);
      b2b = 1'b1;
    end

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    chk("drain", 32'(sb.size()), 32'd0);

    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40;
    be0 = 4'hF; wdata0 = 32'hCAFEF00D;
    n = 0;
    @(negedge clk);
    while (!gnt0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("lat0_gnt", 32'(gnt0), 32'd1);
    @(posedge clk);
    #1;
    we0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("lat0_alternate", 32'({gnt0, rvalid0}),
          (i % 2 == 0) ? 32'd1 : 32'd2);
      if (rvalid0)
        chk("lat0_rdata", rdata0, (i == 0) ? 32'd0 : 32'hCAFEF00D);
    end
    req0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory port. It accepts one load or store request at a time from the core's memory stage over a req/gnt/rvalid handshake. It inserts a programmable number of wait states, performs byte-enabled accesses on an internal word array, and returns read data or a store acknowledgement with an error flag. It sits between the core's MEM stage and the data storage, as the responding end of the data-memory interface.

## Interface

- DEPTH_WORDS, 1024: number of 32-bit words in the array; word index = i_addr[31:2].
- LATENCY, 2: wait cycles between grant and response; legal range 0..15.
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rstn  input  1  asynchronous, active-low reset.
- i_req  input  1  request valid from the core.
- i_we  input  1  1 = store, 0 = load; sampled with i_req.
- i_addr  input  32  byte address.
- i_be  input  4  byte enables; lane k = bits [8k+7:8k].
- i_wdata  input  32  store data, lane-aligned as on the bus.
- o_gnt  output  1  request accepted this cycle.
- o_rvalid  output  1  one-cycle response strobe, for both loads and stores.
- o_rdata  output  32  load data; valid only while o_rvalid is high.
- o_err  output  1  access error; valid only while o_rvalid is high.

## Operation

- **States:**
  - IDLE: ready for a request.
  - WAIT: wait-state counter running.
  - RESP: response cycle.
- **Grant:** o_gnt = i_req & (state == IDLE). It is combinational and asserted in IDLE only.
- **Acceptance (edge where i_req & o_gnt = 1):** latch i_we, i_addr, i_be and i_wdata. Load the counter with LATENCY.
  - LATENCY == 0: go to RESP.
  - Otherwise: go to WAIT.
- **WAIT:** decrement the counter each cycle. On the edge where the counter reaches 1, go to RESP.
- **RESP:** o_rvalid = 1 for exactly one cycle, then return to IDLE. o_gnt stays 0 during RESP. Throughput is at most one access per LATENCY+2 cycles.
- **Legality check** uses the latched values. Legal patterns:
  - Byte: i_be one-hot with addr[1:0] equal to the lane index.
  - Half: 4'b0011 with addr[1:0]=0, or 4'b1100 with addr[1:0]=2.
  - Word: 4'b1111 with addr[1:0]=0.
  - Anything else is an error, including be=0000 and mismatched alignment. addr[31:2] >= DEPTH_WORDS is also an error.
- **Store:**
  - Legal: enabled lanes of i_wdata are written to the array on the edge entering RESP; other lanes are untouched.
  - Error: no array write, o_err = 1.
  - o_rdata = 0 during a store response.
- **Load:**
  - The array word is read on the edge entering RESP.
  - o_rdata = the word with non-enabled lanes forced to 0. It is not shifted; sign or zero extension is done by the core.
  - On error: o_rdata = 0, o_err = 1.
- **Outside RESP:** o_rdata and o_err hold their last values. Consumers must qualify them with o_rvalid.
- **Array:** not reset. Its contents survive i_rstn.
- **Requests while busy:** i_req in WAIT or RESP is ignored (no grant). The core holds i_req until it sees o_gnt.

## Timing

- **Reset values:** state = IDLE, counter = 0, o_gnt follows i_req combinationally, o_rvalid = 0, o_rdata = 0, o_err = 0.
- **Latency:** acceptance at edge E0 gives o_rvalid high in the cycle after edge E0+LATENCY. That is 1 cycle for LATENCY=0 and 3 cycles for LATENCY=2.
- **Store visibility:** a load accepted in the IDLE cycle directly after a store's RESP returns the new data.
- **Reset mid-operation:** i_rstn low in WAIT or RESP goes to IDLE immediately. The pending response is dropped. If the store had not yet reached the RESP-entering edge, the array is not written.
- **Request on return to IDLE:** i_req held high through RESP is granted in the following IDLE cycle. There are no back-to-back grants without an intervening RESP.

## Test plan

- **Store word then load, LATENCY=2:** store addr 0x10, be 1111, wdata 0xDEADBEEF. Then load addr 0x10, be 1111. Expect rvalid 3 cycles after each grant, rdata = 0xDEADBEEF, err = 0.
- **Byte store merge:** preload 0x11223344 at 0x20. Store addr 0x21, be 0010, wdata 0x0000AA00. Word load returns 0x1122AA44. Byte load addr 0x23, be 1000 returns 0x11000000.
- **Misaligned and illegal be:** store addr 0x22, be 1111 gives err = 1 and a later word load at 0x20 is unchanged. Load addr 0x20, be 0101 gives err = 1 and rdata = 0.
- **Out of range:** load addr 4*DEPTH_WORDS (0x1000) gives err = 1, rdata = 0, rvalid still after LATENCY+1 cycles.
- **Busy and LATENCY=0:** with LATENCY=0, a continuous i_req gives gnt every 2nd cycle and rvalid on alternating cycles. With LATENCY=2, i_req during WAIT gives o_gnt = 0.
- **Reset mid-WAIT:** accept a store to 0x30 (data 0x55), assert i_rstn low the next cycle, then release. Expect no rvalid, state IDLE, and a load of 0x30 returning the prior contents.
